arx_conv2d_dram_initiator: RTL and testbench

ARX_CONV2D_DRAM_INITIATOR -- requirements
Module: arx_conv2d_dram_initiator

---
 rtl/arx_conv2d_dram_initiator.sv | 233 +++++++++++++++++++++++
 tb/tb_arx_conv2d_dram_initiator.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arx_conv2d_dram_initiator.sv
// Single-outstanding AXI3 burst initiator: turns one read or write command into
// an INCR burst with 32-bit beats, streaming data through and reporting done/error.
module arx_conv2d_dram_initiator #(
    parameter int BW_ADDR    = 32,
    parameter int BW_DATA    = 32,
    parameter int BW_AXI_TID = 16,
    parameter int TID        = 0
) (
    input  logic                  clk,
    input  logic                  rstnn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [BW_ADDR-1:0]    cmd_addr,
    input  logic [3:0]            cmd_len,

    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [BW_DATA-1:0]    wdata,

    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic [BW_DATA-1:0]    rdata,

    output logic                  done,
    output logic                  error,

    output logic [BW_AXI_TID-1:0] sxawid,
    output logic [BW_ADDR-1:0]    sxawaddr,
    output logic [3:0]            sxawlen,
    output logic [2:0]            sxawsize,
    output logic [1:0]            sxawburst,
    output logic [1:0]            sxawlock,
    output logic [3:0]            sxawcache,
    output logic [2:0]            sxawprot,
    output logic                  sxawvalid,
    input  logic                  sxawready,

    output logic [BW_AXI_TID-1:0] sxwid,
    output logic [BW_DATA-1:0]    sxwdata,
    output logic [BW_DATA/8-1:0]  sxwstrb,
    output logic                  sxwlast,
    output logic                  sxwvalid,
    input  logic                  sxwready,

    input  logic [BW_AXI_TID-1:0] sxbid,
    input  logic [1:0]            sxbresp,
    input  logic                  sxbvalid,
    output logic                  sxbready,

    output logic [BW_AXI_TID-1:0] sxarid,
    output logic [BW_ADDR-1:0]    sxaraddr,
    output logic [3:0]            sxarlen,
    output logic [2:0]            sxarsize,
    output logic [1:0]            sxarburst,
    output logic [1:0]            sxarlock,
    output logic [3:0]            sxarcache,
    output logic [2:0]            sxarprot,
    output logic                  sxarvalid,
    input  logic                  sxarready,

    input  logic [BW_AXI_TID-1:0] sxrid,
    input  logic [BW_DATA-1:0]    sxrdata,
    input  logic [1:0]            sxrresp,
    input  logic                  sxrlast,
    input  logic                  sxrvalid,
    output logic                  sxrready
);

    localparam logic [BW_AXI_TID-1:0] ID = BW_AXI_TID'(TID);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [BW_ADDR-1:0] addr_q;
    logic [3:0]         len_q;
    logic               load;
    logic               reject;
    logic               beat_err;
    logic [12:0]        end_off;

    // A burst may not leave its 4 KB page; end offset is one past the last byte.
    assign end_off = {1'b0, cmd_addr[11:0]} + {7'd0, cmd_len, 2'b00} + 13'd4;
    assign reject  = (cmd_addr[1:0] != 2'b00) || (end_off > 13'd4096);

    assign cmd_ready = (state_q == S_IDLE) && !done_q;
    assign done      = done_q;
    assign error     = error_q;

    assign sxawid    = ID;
    assign sxawaddr  = addr_q;
    assign sxawlen   = len_q;
    assign sxawsize  = 3'b010;
    assign sxawburst = 2'b01;
    assign sxawlock  = 2'b00;
    assign sxawcache = 4'b0000;
    assign sxawprot  = 3'b000;

    assign sxwid     = ID;
    assign sxwdata   = wdata;
    assign sxwstrb   = '1;
    assign sxwlast   = (state_q == S_W) && (cnt_q == len_q);

    assign sxarid    = ID;
    assign sxaraddr  = addr_q;
    assign sxarlen   = len_q;
    assign sxarsize  = 3'b010;
    assign sxarburst = 2'b01;
    assign sxarlock  = 2'b00;
    assign sxarcache = 4'b0000;
    assign sxarprot  = 3'b000;

    assign rdata     = sxrdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        load        = 1'b0;
        beat_err    = 1'b0;
        sxawvalid   = 1'b0;
        sxarvalid   = 1'b0;
        sxwvalid    = 1'b0;
        wdata_ready = 1'b0;
        sxbready    = 1'b0;
        sxrready    = 1'b0;
        rdata_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cnt_d = 4'd0;
                    err_d = 1'b0;
                    if (reject) begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = cmd_write ? S_AW : S_AR;
                    end
                end
            end
            S_AW: begin
                sxawvalid = 1'b1;
                if (sxawready) state_d = S_W;
            end
            S_W: begin
                sxwvalid    = wdata_valid;
                wdata_ready = sxwready;
                if (wdata_valid && sxwready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == len_q) state_d = S_B;
                end
            end
            S_B: begin
                sxbready = 1'b1;
                if (sxbvalid) begin
                    if (sxbid == ID) begin
                        done_d  = 1'b1;
                        error_d = err_q || (sxbresp != 2'b00);
                        state_d = S_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_AR: begin
                sxarvalid = 1'b1;
                if (sxarready) state_d = S_R;
            end
            S_R: begin
                // Foreign-ID beats are drained here and never reach the read stream.
                if (sxrvalid && (sxrid != ID)) begin
                    sxrready = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    rdata_valid = sxrvalid;
                    sxrready    = rdata_ready;
                    if (sxrvalid && rdata_ready) begin
                        beat_err = (sxrresp != 2'b00) || (sxrlast != (cnt_q == len_q));
                        if (cnt_q == len_q) begin
                            done_d  = 1'b1;
                            error_d = err_q || beat_err;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                            err_d = err_q || beat_err;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
        end
    end

endmodule

// File: tb/tb_arx_conv2d_dram_initiator.sv
// Directed bench for arx_conv2d_dram_initiator: AXI slave and stream models plus
// a per-cycle monitor comparing the DUT against command-level expectations.
module tb_arx_conv2d_dram_initiator;

    localparam int BW_ADDR    = 32;
    localparam int BW_DATA    = 32;
    localparam int BW_AXI_TID = 16;
    localparam int TID        = 5;
    localparam logic [15:0] TIDW   = 16'(TID);
    localparam logic [31:0] R_BASE = 32'hA000_0000;

    logic clk = 1'b0;
    logic rstnn = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid, rdata_ready;
    logic [31:0] rdata;
    logic        done, error;
    logic [15:0] sxawid, sxwid, sxbid, sxarid, sxrid;
    logic [31:0] sxawaddr, sxaraddr, sxwdata, sxrdata;
    logic [3:0]  sxawlen, sxarlen, sxawcache, sxarcache, sxwstrb;
    logic [2:0]  sxawsize, sxarsize, sxawprot, sxarprot;
    logic [1:0]  sxawburst, sxarburst, sxawlock, sxarlock, sxbresp, sxrresp;
    logic        sxawvalid, sxawready, sxwlast, sxwvalid, sxwready;
    logic        sxbvalid, sxbready, sxarvalid, sxarready;
    logic        sxrlast, sxrvalid, sxrready;

    arx_conv2d_dram_initiator #(
        .BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA), .BW_AXI_TID(BW_AXI_TID), .TID(TID)
    ) dut (
        .clk(clk), .rstnn(rstnn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .done(done), .error(error),
        .sxawid(sxawid), .sxawaddr(sxawaddr), .sxawlen(sxawlen), .sxawsize(sxawsize),
        .sxawburst(sxawburst), .sxawlock(sxawlock), .sxawcache(sxawcache),
        .sxawprot(sxawprot), .sxawvalid(sxawvalid), .sxawready(sxawready),
        .sxwid(sxwid), .sxwdata(sxwdata), .sxwstrb(sxwstrb), .sxwlast(sxwlast),
        .sxwvalid(sxwvalid), .sxwready(sxwready),
        .sxbid(sxbid), .sxbresp(sxbresp), .sxbvalid(sxbvalid), .sxbready(sxbready),
        .sxarid(sxarid), .sxaraddr(sxaraddr), .sxarlen(sxarlen), .sxarsize(sxarsize),
        .sxarburst(sxarburst), .sxarlock(sxarlock), .sxarcache(sxarcache),
        .sxarprot(sxarprot), .sxarvalid(sxarvalid), .sxarready(sxarready),
        .sxrid(sxrid), .sxrdata(sxrdata), .sxrresp(sxrresp), .sxrlast(sxrlast),
        .sxrvalid(sxrvalid), .sxrready(sxrready)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Command-level expectations
    logic        active = 1'b0;
    logic        exp_write;
    logic [31:0] exp_addr;
    int          exp_len;
    logic        exp_err;
    logic        exp_reject;
    logic [31:0] exp_w[$];
    int          w_beat, r_beat, wlast_beat;
    logic        aw_seen, done_seen, done_err, any_axi;
    int          done_cyc, first_aw_cyc, first_ar_cyc;

    // Slave / stream configuration
    logic [1:0]  cfg_bresp   = 2'b00;
    logic        cfg_bad_bid = 1'b0;
    int          cfg_rgap    = 0;
    logic        cfg_rr_rand = 1'b0;
    logic [31:0] wq[$];
    int          widx = 0;

    function automatic logic spec_reject(input logic [31:0] a, input int len);
        int off;
        off = int'(a[11:0]);
        return ((a % 4) != 0) || (off + 4 * (len + 1) > 4096);
    endfunction

    // AXI slave and user-side streams
    initial begin : slave
        logic aw_hs, w_last_hs, b_hs, r_hs, ar_hs, uw_hs, b_retry;
        int   ar_len_s, r_left, r_idx, r_gap;
        sxawready = 1'b1; sxarready = 1'b1; sxwready = 1'b1;
        sxbvalid = 1'b0; sxbresp = 2'b00; sxbid = '0;
        sxrvalid = 1'b0; sxrdata = '0; sxrresp = 2'b00; sxrlast = 1'b0; sxrid = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b1;
        r_left = 0; r_idx = 0; r_gap = 0; b_retry = 1'b0;
        forever begin
            @(negedge clk);
            aw_hs     = sxawvalid && sxawready;
            ar_hs     = sxarvalid && sxarready;
            ar_len_s  = int'(sxarlen);
            w_last_hs = sxwvalid && sxwready && sxwlast;
            b_hs      = sxbvalid && sxbready;
            r_hs      = sxrvalid && sxrready;
            uw_hs     = wdata_valid && wdata_ready;
            @(posedge clk);
            #1;
            if (!rstnn) begin
                sxbvalid = 1'b0; sxrvalid = 1'b0; r_left = 0; b_retry = 1'b0;
            end else begin
                if (uw_hs) widx++;
                if (w_last_hs) begin
                    sxbvalid = 1'b1;
                    b_retry  = cfg_bad_bid;
                    sxbid    = cfg_bad_bid ? TIDW + 16'd1 : TIDW;
                    sxbresp  = cfg_bad_bid ? 2'b00 : cfg_bresp;
                end else if (b_hs) begin
                    if (b_retry) begin
                        b_retry = 1'b0; sxbid = TIDW; sxbresp = cfg_bresp;
                    end else begin
                        sxbvalid = 1'b0;
                    end
                end
                if (ar_hs) begin
                    r_left = ar_len_s + 1; r_idx = 0; r_gap = cfg_rgap;
                end
                if (r_hs) begin
                    sxrvalid = 1'b0; r_idx++; r_left--; r_gap = cfg_rgap;
                end
                if (!sxrvalid && r_left > 0) begin
                    if (r_gap == 0) begin
                        sxrvalid = 1'b1;
                        sxrdata  = R_BASE + 32'(r_idx);
                        sxrlast  = (r_left == 1);
                        sxrresp  = 2'b00;
                        sxrid    = TIDW;
                    end else begin
                        r_gap--;
                    end
                end
                if (aw_hs) begin end
            end
            wdata_valid = (widx < wq.size());
            wdata       = wdata_valid ? wq[widx] : 32'h0;
            rdata_ready = cfg_rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Per-cycle compare against the command-level expectations
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rstnn) begin
                if (sxawvalid || sxarvalid || sxwvalid) any_axi = 1'b1;
                if (sxawvalid) begin
                    if (first_aw_cyc < 0) first_aw_cyc = cyc;
                    chk("aw_fields", {sxawaddr, sxawlen, sxawsize, sxawburst, sxawid},
                        {exp_addr, 4'(exp_len), 3'b010, 2'b01, TIDW});
                    chk("aw_for_write", exp_write, 1'b1);
                    if (sxawready) aw_seen = 1'b1;
                end
                if (sxwvalid) chk("w_after_aw", aw_seen, 1'b1);
                if (sxwvalid && sxwready) begin
                    chk("wdata", sxwdata, (w_beat < exp_w.size()) ? exp_w[w_beat] : 32'hDEAD_BEEF);
                    chk("wlast", sxwlast, (w_beat == exp_len));
                    chk("wstrb_id", {sxwstrb, sxwid}, {4'hF, TIDW});
                    if (sxwlast) wlast_beat = w_beat + 1;
                    w_beat++;
                end
                if (sxarvalid) begin
                    if (first_ar_cyc < 0) first_ar_cyc = cyc;
                    chk("ar_fields", {sxaraddr, sxarlen, sxarsize, sxarburst, sxarid},
                        {exp_addr, 4'(exp_len), 3'b010, 2'b01, TIDW});
                    chk("ar_for_read", exp_write, 1'b0);
                end
                if (rdata_valid && rdata_ready) begin
                    chk("rdata", rdata, R_BASE + 32'(r_beat));
                    r_beat++;
                end
                if (done) begin
                    chk("done_expected", active, 1'b1);
                    chk("error", error, exp_err);
                    chk("cmd_ready_in_done", cmd_ready, 1'b0);
                    done_seen = 1'b1;
                    done_err  = error;
                    done_cyc  = cyc;
                    active    = 1'b0;
                end
            end
        end
    end

    task automatic issue_cmd(input logic wr, input logic [31:0] addr, input int len,
                             input logic [1:0] bresp, input logic bad_bid, output int acc_cyc);
        logic acc;
        exp_write    = wr;
        exp_addr     = addr;
        exp_len      = len;
        exp_reject   = spec_reject(addr, len);
        exp_err      = exp_reject || (wr && ((bresp != 2'b00) || bad_bid));
        cfg_bresp    = bresp;
        cfg_bad_bid  = bad_bid;
        w_beat = 0; r_beat = 0; wlast_beat = 0;
        aw_seen = 1'b0; done_seen = 1'b0; done_err = 1'b0; any_axi = 1'b0;
        first_aw_cyc = -1; first_ar_cyc = -1; done_cyc = -1;
        active    = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = 4'(len);
        cmd_valid = 1'b1;
        acc = 1'b0;
        acc_cyc = -1;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("cmd_accepted", acc, 1'b1);
    endtask

    task automatic finish_cmd(input int acc_cyc);
        for (int n = 0; n < 3000 && !done_seen; n++) @(posedge clk);
        chk("done_seen", done_seen, 1'b1);
        @(negedge clk);
        chk("cmd_ready_after_done", cmd_ready, 1'b1);
        if (exp_reject) begin
            chk("reject_no_axi", any_axi, 1'b0);
            chk("reject_latency", done_cyc - acc_cyc, 1);
        end else if (exp_write) begin
            chk("aw_latency", first_aw_cyc - acc_cyc, 1);
            chk("w_beats", w_beat, exp_len + 1);
        end else begin
            chk("ar_latency", first_ar_cyc - acc_cyc, 1);
            chk("r_beats", r_beat, exp_len + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic wr, input logic [31:0] addr, input int len,
                           input logic [1:0] bresp, input logic bad_bid);
        int acc_cyc;
        issue_cmd(wr, addr, len, bresp, bad_bid, acc_cyc);
        finish_cmd(acc_cyc);
    endtask

    task automatic load_wdata(input int n, input logic [31:0] base);
        wq.delete();
        exp_w.delete();
        for (int i = 0; i < n; i++) begin
            wq.push_back(base + 32'(i));
            exp_w.push_back(base + 32'(i));
        end
        widx = 0;
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk(nm, {sxawvalid, sxwvalid, sxarvalid, sxbready, sxrready, done, error,
                 wdata_ready, rdata_valid, cmd_ready}, 10'b0000000001);
    endtask

    initial begin : main
        int acc_cyc;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        rstnn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset_outputs");
        @(posedge clk);
        #1;
        rstnn = 1'b1;
        @(negedge clk);
        chk_idle_outputs("post_reset_outputs");
        @(posedge clk);
        #1;

        // Write 0x100, len 3, data 1..4
        load_wdata(4, 32'd1);
        run_cmd(1'b1, 32'h100, 3, 2'b00, 1'b0);
        chk("t_write_wlast_beat", wlast_beat, 4);
        chk("t_write_error", done_err, 1'b0);

        // Read 0x200, len 15, slow slave and random rready
        cfg_rgap = 5; cfg_rr_rand = 1'b1;
        run_cmd(1'b0, 32'h200, 15, 2'b00, 1'b0);
        chk("t_read_beats", r_beat, 16);
        chk("t_read_error", done_err, 1'b0);
        cfg_rgap = 0; cfg_rr_rand = 1'b0;

        // 4 KB crossing and misalignment
        run_cmd(1'b1, 32'hFF8, 3, 2'b00, 1'b0);
        chk("t_4k_error", done_err, 1'b1);
        run_cmd(1'b0, 32'h102, 0, 2'b00, 1'b0);
        chk("t_misaligned_error", done_err, 1'b1);
        // Exactly reaching the page end is legal
        run_cmd(1'b0, 32'hFC0, 15, 2'b00, 1'b0);
        chk("t_page_end_error", done_err, 1'b0);

        // SLVERR then normal write
        load_wdata(1, 32'h77);
        run_cmd(1'b1, 32'h80, 0, 2'b10, 1'b0);
        chk("t_slverr_error", done_err, 1'b1);
        load_wdata(1, 32'h88);
        run_cmd(1'b1, 32'h84, 0, 2'b00, 1'b0);
        chk("t_after_slverr_error", done_err, 1'b0);

        // B with a foreign ID first
        load_wdata(1, 32'h55);
        run_cmd(1'b1, 32'h40, 0, 2'b00, 1'b1);
        chk("t_bad_bid_error", done_err, 1'b1);

        // Reset during an 8-beat read
        issue_cmd(1'b0, 32'h300, 7, 2'b00, 1'b0, acc_cyc);
        for (int n = 0; n < 200 && r_beat < 2; n++) @(posedge clk);
        chk("t_rst_beats_before", (r_beat >= 2), 1'b1);
        #1;
        rstnn  = 1'b0;
        active = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("t_rst_during");
        @(posedge clk);
        #1;
        rstnn = 1'b1;
        @(negedge clk);
        chk_idle_outputs("t_rst_after");
        repeat (3) @(posedge clk);
        chk("t_rst_no_done", done_seen, 1'b0);
        #1;
        load_wdata(2, 32'h11);
        run_cmd(1'b1, 32'h500, 1, 2'b00, 1'b0);
        chk("t_rst_write_beats", w_beat, 2);
        chk("t_rst_write_error", done_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
